// File: rtl/fc_l2_arb_pkg.sv
// Shared types and constants for the FC L2 port arbiter.
package fc_l2_arb_pkg;

    // Requester identifier: one bit is enough for two ports.
    typedef logic port_id_t;

    localparam port_id_t PORT_INSTR = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;

    // Upper bound accepted for MAX_OUTSTANDING.
    localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;

    // The port that is not 'id'.
    function automatic port_id_t other_port(input port_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/xbar_tcdm_bus.sv
// TCDM-style request/grant bus with a separate response channel.
// Handshake: a request is accepted in the cycle where req and gnt are both
// high; the master keeps add/wen/wdata/be stable while req waits for gnt.
// r_valid qualifies r_rdata/r_opc for one cycle, one response per request.
interface XBAR_TCDM_BUS;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic        r_valid;

    modport Master (
        output req, add, wen, wdata, be,
        input  gnt, r_opc, r_rdata, r_valid
    );

    modport Slave (
        input  req, add, wen, wdata, be,
        output gnt, r_opc, r_rdata, r_valid
    );
endinterface

// File: rtl/fc_l2_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions waiting on a response.
// Push and pop may happen in the same cycle, also when the FIFO is full.
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  port_id_t      push_id,
    input  logic          pop,
    output port_id_t      head_id,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    port_id_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push at full is legal then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ID storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id;
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Arbitrates the core instruction and data ports onto one shared L2 port,
// bounds the number of outstanding transactions and routes responses back
// in order to the port that issued each request.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = 2,
    parameter  int unsigned FIXED_PRIO      = 0,
    localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    XBAR_TCDM_BUS.Slave   instr_slave,
    XBAR_TCDM_BUS.Slave   data_slave,
    XBAR_TCDM_BUS.Master  l2_master,
    output logic [CW-1:0] outstanding_o,
    output logic          spurious_rsp_o
);

    logic [1:0] req_vec;
    port_id_t   winner;
    logic       has_winner;
    logic       issue_allowed;
    logic       accept;
    logic       rsp_valid;
    port_id_t   last_grant_q;
    logic       lock_q;
    port_id_t   lock_id_q;
    logic       spurious_q;
    port_id_t   head_id;
    logic       fifo_full;
    logic       fifo_empty;

    assign req_vec = {data_slave.req, instr_slave.req};

    // Pick the port presented to L2: a pending (locked) port keeps priority.
    always_comb begin
        has_winner = 1'b1;
        winner     = PORT_INSTR;
        if (lock_q && req_vec[lock_id_q]) begin
            winner = lock_id_q;
        end else if (&req_vec) begin
            winner = (FIXED_PRIO != 0) ? PORT_DATA : other_port(last_grant_q);
        end else if (req_vec[PORT_DATA]) begin
            winner = PORT_DATA;
        end else if (req_vec[PORT_INSTR]) begin
            winner = PORT_INSTR;
        end else begin
            has_winner = 1'b0;
        end
    end

    // A full FIFO can still take a new ID when a response pops the head this cycle.
    assign issue_allowed = ~fifo_full | l2_master.r_valid;

    assign l2_master.req   = has_winner & issue_allowed;
    assign l2_master.add   = (winner == PORT_DATA) ? data_slave.add   : instr_slave.add;
    assign l2_master.wen   = (winner == PORT_DATA) ? data_slave.wen   : instr_slave.wen;
    assign l2_master.wdata = (winner == PORT_DATA) ? data_slave.wdata : instr_slave.wdata;
    assign l2_master.be    = (winner == PORT_DATA) ? data_slave.be    : instr_slave.be;

    assign accept          = l2_master.req & l2_master.gnt;
    assign instr_slave.gnt = accept & (winner == PORT_INSTR);
    assign data_slave.gnt  = accept & (winner == PORT_DATA);

    // Responses go to the FIFO head only; a response with nothing pending is dropped.
    assign rsp_valid           = l2_master.r_valid & ~fifo_empty;
    assign instr_slave.r_valid = rsp_valid & (head_id == PORT_INSTR);
    assign data_slave.r_valid  = rsp_valid & (head_id == PORT_DATA);
    assign instr_slave.r_rdata = instr_slave.r_valid ? l2_master.r_rdata : '0;
    assign data_slave.r_rdata  = data_slave.r_valid  ? l2_master.r_rdata : '0;
    assign instr_slave.r_opc   = instr_slave.r_valid & l2_master.r_opc;
    assign data_slave.r_opc    = data_slave.r_valid  & l2_master.r_opc;

    assign spurious_rsp_o = spurious_q;

    // Fairness history, selection lock and the sticky spurious-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q <= PORT_DATA;
            lock_q       <= 1'b0;
            lock_id_q    <= PORT_INSTR;
            spurious_q   <= 1'b0;
        end else begin
            if (accept) last_grant_q <= winner;
            lock_q    <= has_winner & ~accept;
            lock_id_q <= winner;
            if (l2_master.r_valid && fifo_empty) spurious_q <= 1'b1;
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (accept),
        .push_id (winner),
        .pop     (rsp_valid),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Bench for fc_l2_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_fc_l2_port_arbiter;
    import fc_l2_arb_pkg::*;

    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned CW      = $clog2(MAX_OUT + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] outstanding;
    logic          spurious;
    int            checks = 0;
    int            errors = 0;

    XBAR_TCDM_BUS instr_bus ();
    XBAR_TCDM_BUS data_bus ();
    XBAR_TCDM_BUS l2_bus ();

    fc_l2_port_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .FIXED_PRIO      (0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_slave    (instr_bus),
        .data_slave     (data_bus),
        .l2_master      (l2_bus),
        .outstanding_o  (outstanding),
        .spurious_rsp_o (spurious)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mdl_q[$];       // IDs of accepted, unanswered requests, oldest first
    int mdl_last = 1;   // port that won the most recent acceptance
    bit mdl_lock = 0;   // a presented request was not accepted last cycle
    int mdl_lock_id = 0;
    bit mdl_spur = 0;
    bit mdl_live = 0;   // model is meaningful once a reset has been seen

    // Compare DUT against the model on every cycle, then advance the model.
    always @(negedge clk) begin : compare_proc
        bit req_i, req_d, has_w, allowed, acc, rsp;
        int w, head;
        req_i = instr_bus.req;
        req_d = data_bus.req;
        has_w = req_i || req_d;
        if (mdl_lock && ((mdl_lock_id == 0 && req_i) || (mdl_lock_id == 1 && req_d)))
            w = mdl_lock_id;
        else if (req_i && req_d)
            w = (mdl_last == 0) ? 1 : 0;
        else
            w = req_d ? 1 : 0;
        allowed = (mdl_q.size() < int'(MAX_OUT)) ||
                  (mdl_q.size() == int'(MAX_OUT) && l2_bus.r_valid);
        acc  = has_w && allowed && l2_bus.gnt;
        rsp  = l2_bus.r_valid && (mdl_q.size() > 0);
        head = rsp ? mdl_q[0] : -1;

        if (mdl_live) begin
            check("cyc_l2_req", 32'(l2_bus.req), 32'(has_w && allowed));
            if (has_w && allowed) begin
                check("cyc_l2_add", l2_bus.add, (w == 1) ? data_bus.add : instr_bus.add);
                check("cyc_l2_wdata", l2_bus.wdata, (w == 1) ? data_bus.wdata : instr_bus.wdata);
                check("cyc_l2_wen_be", 32'({l2_bus.wen, l2_bus.be}),
                      (w == 1) ? 32'({data_bus.wen, data_bus.be}) : 32'({instr_bus.wen, instr_bus.be}));
            end
            check("cyc_instr_gnt", 32'(instr_bus.gnt), 32'(acc && w == 0));
            check("cyc_data_gnt", 32'(data_bus.gnt), 32'(acc && w == 1));
            check("cyc_instr_rvalid", 32'(instr_bus.r_valid), 32'(head == 0));
            check("cyc_data_rvalid", 32'(data_bus.r_valid), 32'(head == 1));
            if (head == 0) begin
                check("cyc_instr_rdata", instr_bus.r_rdata, l2_bus.r_rdata);
                check("cyc_instr_ropc", 32'(instr_bus.r_opc), 32'(l2_bus.r_opc));
            end
            if (head == 1) begin
                check("cyc_data_rdata", data_bus.r_rdata, l2_bus.r_rdata);
                check("cyc_data_ropc", 32'(data_bus.r_opc), 32'(l2_bus.r_opc));
            end
            check("cyc_outstanding", 32'(outstanding), 32'(mdl_q.size()));
            check("cyc_spurious", 32'(spurious), 32'(mdl_spur));
        end

        if (!rst_n) begin
            mdl_q.delete();
            mdl_last = 1;
            mdl_lock = 0;
            mdl_spur = 0;
            mdl_live = 1;
        end else begin
            if (l2_bus.r_valid && mdl_q.size() == 0) mdl_spur = 1;
            if (rsp) void'(mdl_q.pop_front());
            if (acc) begin
                mdl_q.push_back(w);
                mdl_last = w;
            end
            mdl_lock    = has_w && !acc;
            mdl_lock_id = w;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        instr_bus.req = 0; instr_bus.add = '0; instr_bus.wen = 1; instr_bus.wdata = '0; instr_bus.be = '1;
        data_bus.req  = 0; data_bus.add  = '0; data_bus.wen  = 1; data_bus.wdata  = '0; data_bus.be  = '1;
        l2_bus.gnt = 0; l2_bus.r_valid = 0; l2_bus.r_rdata = '0; l2_bus.r_opc = 0;
    endtask

    task automatic drive_random();
        instr_bus.req   = ($urandom_range(0, 2) != 0);
        instr_bus.add   = $urandom;
        instr_bus.wen   = 1'($urandom_range(0, 1));
        instr_bus.wdata = $urandom;
        instr_bus.be    = 4'($urandom_range(0, 15));
        data_bus.req    = ($urandom_range(0, 2) != 0);
        data_bus.add    = $urandom;
        data_bus.wen    = 1'($urandom_range(0, 1));
        data_bus.wdata  = $urandom;
        data_bus.be     = 4'($urandom_range(0, 15));
        l2_bus.gnt      = ($urandom_range(0, 2) != 0);
        l2_bus.r_valid  = (mdl_q.size() > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) == 0);
        l2_bus.r_rdata  = $urandom;
        l2_bus.r_opc    = 1'($urandom_range(0, 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        #1;
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_spurious", 32'(spurious), 32'd0);
        check("rst_l2_req", 32'(l2_bus.req), 32'd0);
        check("rst_gnts", 32'({instr_bus.gnt, data_bus.gnt}), 32'd0);
        check("rst_rvalids", 32'({instr_bus.r_valid, data_bus.r_valid}), 32'd0);
        step();

        // Both ports request every cycle, response one cycle after each grant.
        for (int i = 0; i < 6; i++) begin
            instr_bus.req = 1; instr_bus.add = 32'h1000 + i;
            data_bus.req  = 1; data_bus.add  = 32'h2000 + i;
            l2_bus.gnt = 1;
            l2_bus.r_valid = (i > 0);
            l2_bus.r_rdata = 32'hA000 + i;
            #1;
            check("rr_instr_gnt", 32'(instr_bus.gnt), 32'(i % 2 == 0));
            check("rr_data_gnt", 32'(data_bus.gnt), 32'(i % 2 == 1));
            check("rr_l2_add", l2_bus.add, (i % 2 == 0) ? 32'h1000 + i : 32'h2000 + i);
            if (i > 0) begin
                check("rr_rsp_instr", 32'(instr_bus.r_valid), 32'((i - 1) % 2 == 0));
                check("rr_rsp_data", 32'(data_bus.r_valid), 32'((i - 1) % 2 == 1));
                if ((i - 1) % 2 == 0) check("rr_rdata_instr", instr_bus.r_rdata, 32'hA000 + i);
                else                  check("rr_rdata_data", data_bus.r_rdata, 32'hA000 + i);
            end
            step();
        end
        set_idle();
        l2_bus.r_valid = 1; l2_bus.r_rdata = 32'hA006;
        #1;
        check("rr_drain_data", 32'(data_bus.r_valid), 32'd1);
        step();
        set_idle();
        #1;
        check("rr_outstanding", 32'(outstanding), 32'd0);

        // Make instr the last winner, then hold instr pending while data joins.
        instr_bus.req = 1; instr_bus.add = 32'h0000_0050; l2_bus.gnt = 1;
        step();
        set_idle(); l2_bus.r_valid = 1;
        step();
        set_idle();
        instr_bus.req = 1; instr_bus.add = 32'h0000_00A0;
        #1;
        check("lock_c1_req", 32'(l2_bus.req), 32'd1);
        check("lock_c1_add", l2_bus.add, 32'h0000_00A0);
        check("lock_c1_gnt", 32'(instr_bus.gnt), 32'd0);
        for (int c = 2; c <= 3; c++) begin
            step();
            data_bus.req = 1; data_bus.add = 32'h0000_00B0;
            #1;
            check("lock_hold_add", l2_bus.add, 32'h0000_00A0);
            check("lock_hold_gnts", 32'({instr_bus.gnt, data_bus.gnt}), 32'd0);
        end
        step();
        l2_bus.gnt = 1;
        #1;
        check("lock_c4_instr_gnt", 32'(instr_bus.gnt), 32'd1);
        check("lock_c4_data_gnt", 32'(data_bus.gnt), 32'd0);
        step();
        instr_bus.req = 0;
        #1;
        check("lock_c5_data_gnt", 32'(data_bus.gnt), 32'd1);
        check("lock_c5_add", l2_bus.add, 32'h0000_00B0);
        step();

        // Limit reached: no issue until a response frees a slot.
        data_bus.add = 32'h0000_00C0; l2_bus.gnt = 1;
        #1;
        check("max_l2_req", 32'(l2_bus.req), 32'd0);
        check("max_gnts", 32'({instr_bus.gnt, data_bus.gnt}), 32'd0);
        check("max_outstanding", 32'(outstanding), 32'd2);
        step();
        l2_bus.r_valid = 1; l2_bus.r_rdata = 32'h0000_0033;
        #1;
        check("max_rsp_instr", 32'(instr_bus.r_valid), 32'd1);
        check("max_rsp_rdata", instr_bus.r_rdata, 32'h0000_0033);
        check("max_rsp_data_quiet", 32'(data_bus.r_valid), 32'd0);
        check("max_reissue_gnt", 32'(data_bus.gnt), 32'd1);
        step();
        data_bus.req = 0; l2_bus.gnt = 0; l2_bus.r_rdata = 32'h0000_0044;
        #1;
        check("max_count_stays", 32'(outstanding), 32'd2);
        check("max_rsp2_data", 32'(data_bus.r_valid), 32'd1);
        step();
        #1;
        check("max_rsp3_data", 32'(data_bus.r_valid), 32'd1);
        step();
        set_idle();
        #1;
        check("max_drained", 32'(outstanding), 32'd0);

        // In-order response routing.
        instr_bus.req = 1; instr_bus.add = 32'h100; l2_bus.gnt = 1;
        #1;
        check("ord_issue_a", 32'(instr_bus.gnt), 32'd1);
        step();
        instr_bus.req = 0; data_bus.req = 1; data_bus.add = 32'h200;
        #1;
        check("ord_issue_b", 32'(data_bus.gnt), 32'd1);
        step();
        set_idle(); l2_bus.r_valid = 1; l2_bus.r_rdata = 32'h1111_1111;
        #1;
        check("ord_rsp_a_valid", 32'({instr_bus.r_valid, data_bus.r_valid}), 32'b10);
        check("ord_rsp_a_data", instr_bus.r_rdata, 32'h1111_1111);
        step();
        l2_bus.r_rdata = 32'h2222_2222;
        #1;
        check("ord_rsp_b_valid", 32'({instr_bus.r_valid, data_bus.r_valid}), 32'b01);
        check("ord_rsp_b_data", data_bus.r_rdata, 32'h2222_2222);
        step();
        set_idle();

        // Response with nothing outstanding.
        l2_bus.r_valid = 1; l2_bus.r_rdata = 32'h0000_DEAD;
        #1;
        check("spur_no_rvalid", 32'({instr_bus.r_valid, data_bus.r_valid}), 32'd0);
        check("spur_not_yet", 32'(spurious), 32'd0);
        step();
        set_idle();
        #1;
        check("spur_set", 32'(spurious), 32'd1);
        check("spur_count", 32'(outstanding), 32'd0);
        step();
        #1;
        check("spur_sticky", 32'(spurious), 32'd1);

        // Reset with two outstanding, last winner instr.
        data_bus.req = 1; l2_bus.gnt = 1;
        step();
        data_bus.req = 0; instr_bus.req = 1;
        step();
        set_idle(); rst_n = 0;
        #1;
        check("rst2_before", 32'(outstanding), 32'd2);
        step();
        rst_n = 1;
        #1;
        check("rst2_outstanding", 32'(outstanding), 32'd0);
        check("rst2_spur_clear", 32'(spurious), 32'd0);
        l2_bus.r_valid = 1;
        #1;
        check("rst2_late_rsp", 32'({instr_bus.r_valid, data_bus.r_valid}), 32'd0);
        step();
        set_idle();
        instr_bus.req = 1; data_bus.req = 1; l2_bus.gnt = 1;
        #1;
        check("rst2_spur_set", 32'(spurious), 32'd1);
        check("rst2_conflict", 32'({instr_bus.gnt, data_bus.gnt}), 32'b10);
        step();
        set_idle(); l2_bus.r_valid = 1;
        #1;
        check("rst2_rsp_instr", 32'(instr_bus.r_valid), 32'd1);
        step();
        set_idle();

        // Randomized traffic with occasional resets mid-flight.
        rst_n = 0;
        step();
        rst_n = 1;
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        set_idle();
        rst_n = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
